// File: rtl/glo_ca_code_gen_if.sv
// Chip-stream bundle between the GLONASS C/A code generator and its neighbours.
// master: the code generator (consumes clk_511k/nav_bit, drives the chip outputs).
// slave:  the surrounding logic (divider, data source, modulator).
interface glo_ca_code_gen_if;
  logic       clk_511k;
  logic       nav_bit;
  logic       chip_stb;
  logic       code_chip;
  logic [8:0] chip_idx;
  logic       epoch;
  logic       meander;
  logic       data_req;
  logic       sig_out;

  modport master (
    input  clk_511k, nav_bit,
    output chip_stb, code_chip, chip_idx, epoch, meander, data_req, sig_out
  );

  modport slave (
    output clk_511k, nav_bit,
    input  chip_stb, code_chip, chip_idx, epoch, meander, data_req, sig_out
  );
endinterface

// File: rtl/glo_ca_code_gen.sv
// GLONASS C/A ranging code generator.
// Synchronizes the 511 kHz chip clock, turns its rising edges into chip strobes,
// runs the 9-stage LFSR (g(x)=1+x^5+x^9, output stage 7) and derives the 1 ms
// epoch, 10 ms meander and 20 ms data-bit timing. All chip outputs are
// registered and change only in the cycle where chip_stb is high.
module glo_ca_code_gen #(
  parameter logic [8:0] LFSR_INIT          = 9'h1FF,
  parameter int         CODE_LEN           = 511,
  parameter int         EPOCHS_PER_BIT     = 20,
  parameter int         EPOCHS_PER_MEANDER = 10,
  parameter bit         DATA_EN            = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  glo_ca_code_gen_if.master bus
);

  localparam int         EW       = $clog2(EPOCHS_PER_BIT);
  localparam logic [8:0] LAST_IDX = 9'(CODE_LEN - 1);
  localparam logic [EW-1:0] LAST_EP    = EW'(EPOCHS_PER_BIT - 1);
  localparam logic [EW-1:0] MEANDER_TH = EW'(EPOCHS_PER_MEANDER);

  // synchronizer / edge detect state
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          edge_det;

  // code generator state
  logic          started_q, started_d;
  logic [8:0]    lfsr_q, lfsr_d;
  logic [8:0]    idx_q, idx_d;
  logic [EW-1:0] ep_cnt_q, ep_cnt_d;
  logic          data_bit_q, data_bit_d;
  logic          fb;

  // registered outputs
  logic          chip_stb_q, chip_stb_d;
  logic          code_chip_q, code_chip_d;
  logic          epoch_q, epoch_d;
  logic          meander_q, meander_d;
  logic          data_req_q, data_req_d;
  logic          sig_out_q, sig_out_d;

  // Two-flop synchronizer, edge history and arming.
  // fill_q marks when s2 holds a genuine sample rather than its reset zero, so
  // a chip clock held high across reset release is not mistaken for a low level
  // and cannot produce a strobe.
  always_comb begin
    s1_d     = bus.clk_511k;
    s2_d     = s1_q;
    s3_d     = s2_q;
    fill_d   = {fill_q[0], 1'b1};
    armed_d  = armed_q | (fill_q[1] & ~s2_q);
    edge_det = armed_q & s2_q & ~s3_q;
  end

  // Chip datapath: on each detected edge compute the next chip and all timing outputs.
  always_comb begin
    started_d   = started_q;
    lfsr_d      = lfsr_q;
    idx_d       = idx_q;
    ep_cnt_d    = ep_cnt_q;
    data_bit_d  = data_bit_q;
    chip_stb_d  = edge_det;
    code_chip_d = code_chip_q;
    epoch_d     = 1'b0;
    meander_d   = meander_q;
    data_req_d  = 1'b0;
    sig_out_d   = sig_out_q;
    fb          = lfsr_q[4] ^ lfsr_q[8];
    if (edge_det) begin
      if (!started_q || idx_q == LAST_IDX) begin
        // first chip after reset, or code wrap: restart at chip 0 from the load value
        lfsr_d    = LFSR_INIT;
        idx_d     = 9'd0;
        epoch_d   = 1'b1;
        started_d = 1'b1;
        if (started_q)
          ep_cnt_d = (ep_cnt_q == LAST_EP) ? '0 : ep_cnt_q + EW'(1);
      end else begin
        lfsr_d = {lfsr_q[7:0], fb};
        idx_d  = idx_q + 9'd1;
      end
      code_chip_d = lfsr_d[6];
      meander_d   = (ep_cnt_d >= MEANDER_TH);
      // data-bit boundary: latch the new navigation bit in the same cycle it is used
      if (epoch_d && ep_cnt_d == '0) begin
        data_req_d = 1'b1;
        data_bit_d = bus.nav_bit;
      end
      sig_out_d = DATA_EN ? (code_chip_d ^ data_bit_d ^ meander_d) : code_chip_d;
    end
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      fill_q      <= 2'b00;
      armed_q     <= 1'b0;
      started_q   <= 1'b0;
      lfsr_q      <= LFSR_INIT;
      idx_q       <= 9'd0;
      ep_cnt_q    <= '0;
      data_bit_q  <= 1'b0;
      chip_stb_q  <= 1'b0;
      code_chip_q <= 1'b0;
      epoch_q     <= 1'b0;
      meander_q   <= 1'b0;
      data_req_q  <= 1'b0;
      sig_out_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      started_q   <= started_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      ep_cnt_q    <= ep_cnt_d;
      data_bit_q  <= data_bit_d;
      chip_stb_q  <= chip_stb_d;
      code_chip_q <= code_chip_d;
      epoch_q     <= epoch_d;
      meander_q   <= meander_d;
      data_req_q  <= data_req_d;
      sig_out_q   <= sig_out_d;
    end
  end

  assign bus.chip_stb  = chip_stb_q;
  assign bus.code_chip = code_chip_q;
  assign bus.chip_idx  = idx_q;
  assign bus.epoch     = epoch_q;
  assign bus.meander   = meander_q;
  assign bus.data_req  = data_req_q;
  assign bus.sig_out   = sig_out_q;

endmodule

// File: tb/tb_glo_ca_code_gen.sv
// Bench for glo_ca_code_gen: one instance with data modulation, one without,
// driven by the same chip clock. Expected chips are queued as each chip-clock
// edge is driven; a negedge monitor pops and compares on every chip_stb.
module tb_glo_ca_code_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_511k = 1'b1;
  logic nav_bit = 1'b0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glo_ca_code_gen_if ifa ();
  glo_ca_code_gen_if ifb ();
  assign ifa.clk_511k = clk_511k;
  assign ifa.nav_bit  = nav_bit;
  assign ifb.clk_511k = clk_511k;
  assign ifb.nav_bit  = nav_bit;

  glo_ca_code_gen #(.DATA_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  glo_ca_code_gen #(.DATA_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic       code;
    logic [8:0] idx;
    logic       ep;
    logic       mea;
    logic       dreq;
    logic       sig;
    longint     drv_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic cref[0:510];
  int   gen_n = 0;
  logic cur_bit = 1'b0;

  // Reference code from the recurrence b[t+9] = b[t+4] ^ b[t] over the bit
  // stream that enters stage 1, starting with nine ones; chip n is stage 7
  // after n shifts, i.e. b[n+2].
  task automatic build_ref();
    logic bseq[0:520];
    for (int i = 0; i < 9; i++) bseq[i] = 1'b1;
    for (int t = 0; t + 9 <= 520; t++) bseq[t+9] = bseq[t+4] ^ bseq[t];
    for (int n = 0; n < 511; n++) cref[n] = bseq[n+2];
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Queue the expected chip for strobe gen_n, then drive one chip-clock period.
  task automatic issue_chip();
    exp_t e;
    int idx = gen_n % 511;
    int ep  = (gen_n / 511) % 20;
    int j   = gen_n / (511 * 20);
    e.code = cref[idx];
    e.idx  = 9'(idx);
    e.ep   = (idx == 0);
    e.mea  = (ep >= 10);
    e.dreq = e.ep && (ep == 0);
    if (e.dreq) begin
      cur_bit = (j == 0) ? 1'b1 : (j == 1) ? 1'b0 : 1'($urandom % 2);
      nav_bit = cur_bit;
    end
    e.sig     = e.code ^ cur_bit ^ e.mea;
    e.drv_cyc = cyc;
    q.push_back(e);
    clk_511k = 1'b1;
    wait_neg(2 + (($urandom % 4) == 0 ? 1 : 0));
    clk_511k = 1'b0;
    wait_neg(2);
    // the held bit must survive nav_bit changing after data_req
    if (e.dreq || ($urandom % 8) == 0) nav_bit = 1'($urandom % 2);
    gen_n++;
  endtask

  task automatic check_outs_zero(input string name);
    logic [14:0] va, vb;
    va = {ifa.chip_stb, ifa.code_chip, ifa.chip_idx, ifa.epoch, ifa.meander, ifa.data_req, ifa.sig_out};
    vb = {ifb.chip_stb, ifb.code_chip, ifb.chip_idx, ifb.epoch, ifb.meander, ifb.data_req, ifb.sig_out};
    checks++;
    if (va !== 15'd0) begin
      errors++;
      $display("FAIL %s_a: outputs=%h expected 0", name, va);
    end
    checks++;
    if (vb !== 15'd0) begin
      errors++;
      $display("FAIL %s_b: outputs=%h expected 0", name, vb);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missed_strobes: pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compares every strobe of both instances against the queued model.
  int   mon_n = 0;
  int   ones  = 0;
  logic [0:12] first13 = 13'b1111111000001;
  initial begin
    exp_t e;
    longint lat;
    logic [13:0] act, req;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_n = 0;
        ones  = 0;
      end else if (ifa.chip_stb) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_stb: chip_idx=%0d with no chip-clock edge pending", ifa.chip_idx);
        end else begin
          e   = q.pop_front();
          act = {ifa.code_chip, ifa.chip_idx, ifa.epoch, ifa.meander, ifa.data_req, ifa.sig_out};
          req = {e.code, e.idx, e.ep, e.mea, e.dreq, e.sig};
          if (act !== req) begin
            errors++;
            $display("FAIL chip_a n=%0d: {code,idx,ep,mea,dreq,sig}=%h expected %h", mon_n, act, req);
          end
          checks++;
          act = {ifb.code_chip, ifb.chip_idx, ifb.epoch, ifb.meander, ifb.data_req, ifb.sig_out};
          req = {e.code, e.idx, e.ep, e.mea, e.dreq, e.code};
          if (!ifb.chip_stb || act !== req) begin
            errors++;
            $display("FAIL chip_b n=%0d: stb=%b {code,idx,ep,mea,dreq,sig}=%h expected stb=1 %h",
                     mon_n, ifb.chip_stb, act, req);
          end
          checks++;
          lat = cyc - e.drv_cyc;
          if (lat < 3 || lat > 4) begin
            errors++;
            $display("FAIL latency n=%0d: %0d cycles expected 3..4", mon_n, lat);
          end
          if (mon_n < 13) begin
            checks++;
            if (ifa.code_chip !== first13[mon_n]) begin
              errors++;
              $display("FAIL first13 n=%0d: code=%b expected %b", mon_n, ifa.code_chip, first13[mon_n]);
            end
          end
          if (mon_n < 511 && ifa.code_chip === 1'b1) ones++;
          if (mon_n == 510) begin
            checks++;
            if (ones != 256) begin
              errors++;
              $display("FAIL ones_per_period: %0d expected 256", ones);
            end
          end
        end
        mon_n++;
      end else if (ifb.chip_stb) begin
        checks++;
        errors++;
        $display("FAIL stb_b_alone: dut_b strobed without dut_a");
      end
    end
  end

  initial begin
    build_ref();
    // reset with the chip clock high, released while it stays high
    wait_neg(3);
    check_outs_zero("reset");
    rst = 1'b0;
    wait_neg(10);
    clk_511k = 1'b0;
    wait_neg(2);
    // phase 1: 20 epochs plus the start of the next data bit
    for (int i = 0; i < 20 * 511 + 3; i++) issue_chip();
    drain();

    // phase 2: fresh reset, run to chip 300 of epoch 5, then reset mid-operation
    rst = 1'b1;
    #1;
    check_outs_zero("reset2");
    gen_n = 0;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(3);
    for (int i = 0; i < 5 * 511 + 301; i++) issue_chip();
    drain();
    rst = 1'b1;
    #1;
    check_outs_zero("mid_reset");
    gen_n = 0;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(3);
    for (int i = 0; i < 40; i++) issue_chip();
    drain();
    wait_neg(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glo_ca_code_gen.md
Name: glo_ca_code_gen

Overview:
- Downstream consumer of the GLONASS 511 kHz chip-rate clock. Samples `clk_511k` into the system clock domain and turns its rising edges into one-cycle chip strobes.
- Generates the 511-chip GLONASS C/A ranging code: 9-stage LFSR, g(x)=1+x^5+x^9, output taken from stage 7.
- Produces the 1 ms code epoch, the 10 ms meander and the 20 ms navigation-bit timing.
- Outputs the modulated chip stream to the carrier/modulator stage.

Parameters:
LFSR_INIT, 9'h1FF, LFSR load value at reset and at every code wrap (stage1 = bit0 … stage9 = bit8)
CODE_LEN, 511, chips per code period
EPOCHS_PER_BIT, 20, code epochs per navigation data bit
EPOCHS_PER_MEANDER, 10, code epochs per meander half-period
DATA_EN, 1, 1 = modulate data and meander onto `sig_out`; 0 = `sig_out` is the bare code

Ports:
clk  input  1  system clock; must be at least 4x the frequency of `clk_511k`
rst  input  1  reset, asynchronous, active-high
clk_511k  input  1  chip-rate clock from the divider; asynchronous to `clk` in timing terms
nav_bit  input  1  navigation data bit; sampled when `data_req`=1
chip_stb  output  1  one-cycle pulse; all chip outputs update in this cycle
code_chip  output  1  current C/A code chip
chip_idx  output  9  index of the current chip, 0..CODE_LEN-1
epoch  output  1  high for exactly the `clk` cycle in which chip 0 is issued
meander  output  1  0 for epochs 0..9 of a bit, 1 for epochs 10..19
data_req  output  1  one-cycle pulse at each data-bit boundary
sig_out  output  1  code_chip ^ data_bit ^ meander (DATA_EN=1), else code_chip

Behaviour:
- Reset (async, immediate): all outputs 0; LFSR=LFSR_INIT; chip, epoch and bit counters 0; held data bit 0; synchronizer flops and edge-history flop 0; `armed`=0; `started`=0.
- Synchronizer: two flops, s1 then s2.
- Arming: `armed` sets on the first post-reset cycle with s2=0. A `clk_511k` held high through reset release therefore never produces a strobe.
- Edge detect: edge = armed & s2 & ~s3, where s3 is the registered copy of s2.
  - `chip_stb` is a register loaded with edge.
  - Latency from the `clk_511k` rising edge to `chip_stb`: 3–4 `clk` cycles.
- On each strobe cycle, all chip outputs are registered together with `chip_stb`=1.
- If `started`=0 (first strobe after reset):
  - Issue chip 0: code_chip = LFSR stage7 of LFSR_INIT (=1); chip_idx=0; epoch=1.
  - Set `started`. Do not shift the LFSR on this strobe.
- Otherwise, when chip_idx = CODE_LEN-1 (wrap):
  - Reload LFSR = LFSR_INIT. Issue chip 0: chip_idx=0, code_chip=1, epoch=1.
  - Advance the epoch counter, wrapping at EPOCHS_PER_BIT-1 → 0.
- Otherwise (normal strobe):
  - Shift: fb = s5^s9; stage1<=fb; stage k<=stage k-1.
  - code_chip = new stage7; chip_idx+1; epoch=0.
- Epoch counter: 0 after reset; it is the value used for the first epoch.
- Meander: meander = (epoch counter >= EPOCHS_PER_MEANDER), updated together with `epoch`.
- Data-bit boundary: on an `epoch` strobe with epoch counter = 0 (including the first strobe):
  - data_req=1 in that cycle.
  - The held data bit <= nav_bit, sampled in the same cycle. Upstream must hold nav_bit valid until data_req, then may change it.
- `epoch`, `data_req` and `chip_stb` are one `clk` wide; all other outputs hold between strobes.
- sig_out is registered and updated on strobe cycles only. On the `data_req` cycle it uses the newly sampled bit.
- Rate constraint: two `clk_511k` edges closer than 2 `clk` cycles are not guaranteed to be detected. No error flag is provided.
- Mid-operation reset:
  - All state returns to reset values.
  - Sequence restarts at chip 0 on the first valid edge after re-arming.
  - No partial chip is emitted.

Test Plan:
- Reset release with clk_511k=1 and held high for 10 clk cycles → no chip_stb. First strobe follows the first low→high transition, 3–4 clk after the edge.
- First 13 strobes after reset → code_chip = 1,1,1,1,1,1,1,0,0,0,0,0,1; chip_idx 0..12; epoch=1 only on strobe 0.
- 1022 strobes → epoch at strobes 0 and 511; chips 511..1021 identical to chips 0..510. Exactly 256 ones per period.
- Run 40 epochs with nav_bit=1 then 0, changed right after data_req:
  - data_req at epochs 0 and 20.
  - meander 0 for epochs 0–9 and 20–29, 1 for epochs 10–19 and 30–39.
  - sig_out = code ^ 1 ^ meander for bit 0, code ^ 0 ^ meander for bit 1.
- DATA_EN=0, nav_bit toggling → sig_out == code_chip on every strobe.
- Assert rst during chip 300 of epoch 5 → all outputs 0 immediately. After release, the first strobe gives chip_idx=0, code_chip=1, epoch=1, data_req=1, meander=0.
